// File: rtl/peripheral_biu_pkg.sv
// Shared AHB3-Lite constants and the command record used by the timer bus initiator.
// AHB_ADDR_W/AHB_DATA_W size the command record and must match the initiator's HADDR_SIZE/HDATA_SIZE.
package peripheral_biu_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE  = 3'b000;
   localparam logic [2:0] HSIZE_HWORD = 3'b001;
   localparam logic [2:0] HSIZE_WORD  = 3'b010;
   localparam logic [2:0] HSIZE_DWORD = 3'b011;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [3:0] HPROT_DATA    = 4'b0011;

   localparam int AHB_ADDR_W = 32;
   localparam int AHB_DATA_W = 32;

   typedef struct packed {
      logic                  write;
      logic [AHB_ADDR_W-1:0] addr;
      logic [2:0]            size;
      logic [AHB_DATA_W-1:0] wdata;
   } ahb_cmd_t;

   typedef enum logic {
      ERR_NORMAL,
      ERR_SECOND
   } err_state_t;

endpackage

// File: rtl/peripheral_timer_ahb_initiator.sv
// AHB3-Lite single-transfer initiator: a valid/ready command port feeds a pipelined
// address stage (A) and data stage (D); each transfer returns a one-cycle response strobe.
module peripheral_timer_ahb_initiator
   import peripheral_biu_pkg::*;
#(
   parameter int HADDR_SIZE = AHB_ADDR_W,
   parameter int HDATA_SIZE = AHB_DATA_W
) (
   input  logic                  HRESETn,
   input  logic                  HCLK,

   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [HADDR_SIZE-1:0] cmd_addr,
   input  logic [2:0]            cmd_size,
   input  logic [HDATA_SIZE-1:0] cmd_wdata,

   output logic                  rsp_valid,
   output logic [HDATA_SIZE-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  busy,

   output logic                  HSEL,
   output logic [HADDR_SIZE-1:0] HADDR,
   output logic                  HWRITE,
   output logic [2:0]            HSIZE,
   output logic [HDATA_SIZE-1:0] HWDATA,
   output logic [2:0]            HBURST,
   output logic [3:0]            HPROT,
   output logic [1:0]            HTRANS,
   output logic                  HMASTLOCK,
   input  logic [HDATA_SIZE-1:0] HRDATA,
   input  logic                  HREADY,
   input  logic                  HRESP
);

   ahb_cmd_t                a_cmd;
   ahb_cmd_t                cmd_in;
   logic                    a_valid;
   logic                    d_valid;
   logic                    d_write;
   logic [HDATA_SIZE-1:0]   d_wdata;
   err_state_t              err_state;

   logic                    err_hold;
   logic                    issue;
   logic                    advance;
   logic                    accept;
   logic                    retire;

   // Handshake: a command transfers on any posedge where cmd_valid & cmd_ready; cmd_ready
   // never looks at cmd_valid, and the caller holds its fields stable until that edge.
   assign err_hold  = (err_state == ERR_SECOND);
   assign issue     = a_valid & ~err_hold;
   assign advance   = issue & HREADY;
   assign cmd_ready = ~a_valid | (HREADY & ~err_hold);
   assign accept    = cmd_valid & cmd_ready;
   assign retire    = d_valid & HREADY;

   assign cmd_in = '{write: cmd_write,
                     addr:  AHB_ADDR_W'(cmd_addr),
                     size:  cmd_size,
                     wdata: AHB_DATA_W'(cmd_wdata)};

   // Address stage: reloads on accept, otherwise empties once its NONSEQ is taken.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         a_valid <= 1'b0;
         a_cmd   <= '0;
      end else if (accept) begin
         a_valid <= 1'b1;
         a_cmd   <= cmd_in;
      end else if (advance) begin
         a_valid <= 1'b0;
      end
   end

   // Data stage: a new entry arriving from A overrides retirement of the old one.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         d_valid <= 1'b0;
         d_write <= 1'b0;
         d_wdata <= '0;
      end else if (advance) begin
         d_valid <= 1'b1;
         d_write <= a_cmd.write;
         d_wdata <= HDATA_SIZE'(a_cmd.wdata);
      end else if (retire) begin
         d_valid <= 1'b0;
      end
   end

   // ERR_SECOND covers the second ERROR cycle, during which the pending address is held back.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         err_state <= ERR_NORMAL;
      end else begin
         case (err_state)
            ERR_NORMAL: if (d_valid & (HRESP == HRESP_ERROR) & ~HREADY) err_state <= ERR_SECOND;
            ERR_SECOND: if (HREADY) err_state <= ERR_NORMAL;
            default:    err_state <= ERR_NORMAL;
         endcase
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= retire;
         rsp_err   <= retire & (HRESP == HRESP_ERROR);
         rsp_rdata <= (retire & (HRESP == HRESP_OKAY) & ~d_write) ? HRDATA : '0;
      end
   end

   assign HTRANS    = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign HSEL      = issue;
   assign HADDR     = HADDR_SIZE'(a_cmd.addr);
   assign HWRITE    = a_cmd.write;
   assign HSIZE     = a_cmd.size;
   assign HWDATA    = d_wdata;
   assign HBURST    = HBURST_SINGLE;
   assign HPROT     = HPROT_DATA;
   assign HMASTLOCK = 1'b0;
   assign busy      = a_valid | d_valid;

endmodule

// File: tb/tb_peripheral_timer_ahb_initiator.sv
// Bench for peripheral_timer_ahb_initiator driving a small timer-like slave model with
// optional wait states and a two-cycle ERROR response at 0xF00.
module tb_peripheral_timer_ahb_initiator;
   import peripheral_biu_pkg::*;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [2:0]  cmd_size;
   logic        rsp_valid, rsp_err, busy;
   logic [31:0] rsp_rdata;
   logic        HSEL, HWRITE, HMASTLOCK, HREADY, HRESP;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic [2:0]  HSIZE, HBURST;
   logic [3:0]  HPROT;
   logic [1:0]  HTRANS;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int rsp_cnt = 0;
   int last_rsp_cyc = 0;
   int ws_cfg = 0;
   logic [32:0] exp_q[$];

   always #5 HCLK = ~HCLK;
   always @(posedge HCLK) cyc <= cyc + 1;

   peripheral_timer_ahb_initiator #(.HADDR_SIZE(32), .HDATA_SIZE(32)) dut (
      .HRESETn(HRESETn), .HCLK(HCLK),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
      .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
      .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
      .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
   );

   // Slave model: 16 word registers, 0x8 reads back tint, writing 0x0 restarts the counter.
   logic        dp_valid, dp_write, err_ph2, tint;
   logic [31:0] dp_addr, tcount;
   logic [31:0] mem [16];
   int          ws_left;

   assign tint = mem[3][0] && ({mem[7], mem[6]} <= {32'b0, tcount});

   always_comb begin
      HREADY = 1'b1;
      HRESP  = 1'b0;
      HRDATA = '0;
      if (dp_valid) begin
         if (dp_addr == 32'hF00) begin
            HRESP  = 1'b1;
            HREADY = err_ph2;
         end else if (ws_left != 0) begin
            HREADY = 1'b0;
         end
         if (!dp_write) HRDATA = (dp_addr[5:2] == 4'd2) ? {31'b0, tint} : mem[dp_addr[5:2]];
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dp_valid <= 1'b0;
         dp_write <= 1'b0;
         dp_addr  <= '0;
         err_ph2  <= 1'b0;
         ws_left  <= 0;
         tcount   <= '0;
         for (int i = 0; i < 16; i++) mem[i] <= '0;
      end else begin
         tcount <= tcount + 1;
         if (HREADY) begin
            if (dp_valid && dp_write && !HRESP) begin
               mem[dp_addr[5:2]] <= HWDATA;
               if (dp_addr[5:2] == 4'd0) tcount <= '0;
            end
            dp_valid <= HSEL && (HTRANS == HTRANS_NONSEQ);
            dp_addr  <= HADDR;
            dp_write <= HWRITE;
            ws_left  <= ws_cfg;
            err_ph2  <= 1'b0;
         end else begin
            if (ws_left != 0) ws_left <= ws_left - 1;
            if (HRESP) err_ph2 <= 1'b1;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Response scoreboard: every strobe must match the oldest expectation.
   always @(negedge HCLK) begin : rsp_monitor
      logic [32:0] e;
      if (rsp_valid) begin
         rsp_cnt++;
         last_rsp_cyc = cyc;
         check("rsp_expected", {63'b0, exp_q.size() != 0}, 64'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rsp_err", {63'b0, rsp_err}, {63'b0, e[32]});
            check("rsp_rdata", {32'b0, rsp_rdata}, {32'b0, e[31:0]});
         end
      end
   end

   // Called shortly after a negedge; returns at the negedge following the accepting posedge.
   task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input bit track,
                        output int acc);
      int n;
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_size  = HSIZE_WORD;
      cmd_wdata = wdata;
      #1;
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(negedge HCLK);
         #1;
         n++;
      end
      check("accept_ready", {63'b0, cmd_ready}, 64'd1);
      acc = cyc;
      if (track) exp_q.push_back({exp_err, exp_rdata});
      @(negedge HCLK);
   endtask

   task automatic wait_rsps(input int target);
      int n;
      n = 0;
      while (rsp_cnt < target && n < 200) begin
         @(negedge HCLK);
         #2;
         n++;
      end
      check("rsp_count", 64'(rsp_cnt), 64'(target));
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int acc, acc_a, base, cnt0, n;
      HRESETn   = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_size  = HSIZE_WORD;
      cmd_wdata = '0;

      #12;
      check("rst_htrans", 64'(HTRANS), 64'(HTRANS_IDLE));
      check("rst_hsel", 64'(HSEL), 64'd0);
      check("rst_haddr", 64'(HADDR), 64'd0);
      check("rst_hwdata", 64'(HWDATA), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_err", 64'(rsp_err), 64'd0);
      check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      check("rst_fixed", {55'b0, HBURST, HPROT, HMASTLOCK, 1'b0}, {55'b0, HBURST_SINGLE, HPROT_DATA, 2'b00});
      @(negedge HCLK);
      @(negedge HCLK);
      HRESETn = 1'b1;
      @(negedge HCLK);

      // 1: single write then read, zero-wait latency
      issue(1'b1, 32'h0, 32'h3, 32'h0, 1'b0, 1'b1, acc);
      cmd_valid = 1'b0;
      check("t1_nonseq", 64'(HTRANS), 64'(HTRANS_NONSEQ));
      check("t1_haddr", 64'(HADDR), 64'h0);
      check("t1_hwrite", 64'(HWRITE), 64'd1);
      wait_rsps(1);
      check("t1_wr_latency", 64'(last_rsp_cyc - acc), 64'd3);
      issue(1'b0, 32'h0, 32'h0, 32'h3, 1'b0, 1'b1, acc);
      cmd_valid = 1'b0;
      wait_rsps(2);
      check("t1_rd_latency", 64'(last_rsp_cyc - acc), 64'd3);

      // 2: back-to-back stream
      base = rsp_cnt;
      issue(1'b1, 32'h18, 32'h20, 32'h0, 1'b0, 1'b1, acc);
      check("t2_nonseq0", 64'(HTRANS), 64'(HTRANS_NONSEQ));
      check("t2_haddr0", 64'(HADDR), 64'h18);
      issue(1'b1, 32'h1C, 32'h0, 32'h0, 1'b0, 1'b1, acc);
      check("t2_nonseq1", 64'(HTRANS), 64'(HTRANS_NONSEQ));
      check("t2_haddr1", 64'(HADDR), 64'h1C);
      check("t2_hwdata0", 64'(HWDATA), 64'h20);
      issue(1'b0, 32'h18, 32'h0, 32'h20, 1'b0, 1'b1, acc);
      cmd_valid = 1'b0;
      check("t2_nonseq2", 64'(HTRANS), 64'(HTRANS_NONSEQ));
      check("t2_haddr2", 64'(HADDR), 64'h18);
      check("t2_hwrite2", 64'(HWRITE), 64'd0);
      wait_rsps(base + 3);

      // 3: three wait states on the write's data phase, read queued behind it
      base = rsp_cnt;
      ws_cfg = 3;
      issue(1'b1, 32'h10, 32'h55, 32'h0, 1'b0, 1'b1, acc_a);
      issue(1'b0, 32'h10, 32'h0, 32'h55, 1'b0, 1'b1, acc);
      cmd_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("t3_htrans", 64'(HTRANS), 64'(HTRANS_NONSEQ));
         check("t3_haddr", 64'(HADDR), 64'h10);
         check("t3_hwdata", 64'(HWDATA), 64'h55);
         check("t3_cmd_ready", 64'(cmd_ready), 64'd0);
         @(negedge HCLK);
      end
      wait_rsps(base + 1);
      check("t3_wr_latency", 64'(last_rsp_cyc - acc_a), 64'd6);
      wait_rsps(base + 2);
      ws_cfg = 0;

      // 4: two-cycle ERROR with a command queued in stage A
      base = rsp_cnt;
      issue(1'b0, 32'hF00, 32'h0, 32'h0, 1'b1, 1'b1, acc);
      issue(1'b1, 32'h14, 32'h77, 32'h0, 1'b0, 1'b1, acc);
      cmd_valid = 1'b0;
      check("t4_queued_nonseq", 64'(HTRANS), 64'(HTRANS_NONSEQ));
      @(negedge HCLK);
      check("t4_err2_idle", 64'(HTRANS), 64'(HTRANS_IDLE));
      check("t4_err2_hsel", 64'(HSEL), 64'd0);
      check("t4_err2_ready", 64'(cmd_ready), 64'd0);
      @(negedge HCLK);
      check("t4_reissue", 64'(HTRANS), 64'(HTRANS_NONSEQ));
      check("t4_reissue_addr", 64'(HADDR), 64'h14);
      check("t4_rsp_err", {62'b0, rsp_valid, rsp_err}, 64'd3);
      wait_rsps(base + 2);
      issue(1'b0, 32'h14, 32'h0, 32'h77, 1'b0, 1'b1, acc);
      cmd_valid = 1'b0;
      wait_rsps(base + 3);

      // 5: reset during a data phase drops the transfer
      issue(1'b1, 32'h24, 32'h99, 32'h0, 1'b0, 1'b0, acc);
      cmd_valid = 1'b0;
      @(posedge HCLK);
      #1;
      check("t5_busy_pre", 64'(busy), 64'd1);
      HRESETn = 1'b0;
      #1;
      check("t5_htrans", 64'(HTRANS), 64'(HTRANS_IDLE));
      check("t5_hsel", 64'(HSEL), 64'd0);
      check("t5_haddr", 64'(HADDR), 64'd0);
      check("t5_hwdata", 64'(HWDATA), 64'd0);
      check("t5_busy", 64'(busy), 64'd0);
      check("t5_cmd_ready", 64'(cmd_ready), 64'd1);
      check("t5_rsp", {30'b0, rsp_valid, rsp_err, rsp_rdata}, 64'd0);
      cnt0 = rsp_cnt;
      @(negedge HCLK);
      @(negedge HCLK);
      HRESETn = 1'b1;
      repeat (6) @(negedge HCLK);
      #2;
      check("t5_no_rsp", 64'(rsp_cnt), 64'(cnt0));

      // 6: program the timer and read back the interrupt status
      base = rsp_cnt;
      issue(1'b1, 32'hC, 32'h1, 32'h0, 1'b0, 1'b1, acc);
      issue(1'b1, 32'h18, 32'h10, 32'h0, 1'b0, 1'b1, acc);
      issue(1'b1, 32'h1C, 32'h0, 32'h0, 1'b0, 1'b1, acc);
      issue(1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
      cmd_valid = 1'b0;
      wait_rsps(base + 4);
      n = 0;
      while (!tint && n < 100) begin
         @(negedge HCLK);
         n++;
      end
      check("t6_tint", 64'(tint), 64'd1);
      #2;
      issue(1'b0, 32'h8, 32'h0, 32'h1, 1'b0, 1'b1, acc);
      cmd_valid = 1'b0;
      wait_rsps(base + 5);

      repeat (3) @(negedge HCLK);
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);
      check("final_idle", {62'b0, busy, rsp_valid}, 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
